keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//  Sequences the 6-column key/switch matrix: steps a column strobe through columns 0..5 with wrap,
//  samples the row lines, debounces a press, and hands one key code to the consumer via valid/ack.
//  Sits between the matrix I/O pins and the input-decoding logic; owns the column counter.
// PARAMETERS
//  N_COLS    6     number of matrix columns (scan wraps N_COLS-1 -> 0)
//  N_ROWS    4     number of row inputs
//  SCAN_DIV  1000  CLK cycles per column dwell (>=2); last cycle of a dwell = "tick"
//  DEBOUNCE  3     consecutive ticks required to accept press or release (>=1)
//  RPT_DLY   50    ticks between auto-repeats (used only with KEYPAD_REPEAT_EN)
// PORTS
//  CLK        in   1            clock
//  CLR        in   1            reset, asynchronous, active-high
//  en         in   1            scan enable
//  row_in     in   N_ROWS       row lines, active-high, asynchronous to CLK
//  col_sel    out  clog2(N_COLS) index of the driven column
//  col_oh     out  N_COLS       one-hot column strobe, bit col_sel high
//  key_code   out  clog2(N_COLS*N_ROWS) col*N_ROWS+row of the accepted key
//  key_valid  out  1            key_code valid; held until key_ack
//  key_ack    in   1            consumer accepts key_code in cycle key_valid&key_ack
// BEHAVIOUR
//  Reset: state IDLE, col_sel=0, col_oh=...0001, key_code=0, key_valid=0, divider=0, sync flops=0.
//  row_in passes a 2-flop synchronizer; samples are the synchronized value (2-cycle latency).
//  Divider counts 0..SCAN_DIV-1 and is cleared on every column change and on entry to SCAN.
//  Row encode: lowest-index high row wins; "none" when all rows low.
//  FSM:
//   IDLE    : en=0. Column held at 0. en=1 -> SCAN next cycle.
//   SCAN    : at tick, if row != none: latch cand_row, column frozen, cnt=1 -> CONFIRM
//             (DEBOUNCE=1 -> directly to HOLD with key_valid); else advance column (wrap to 0).
//   CONFIRM : at each tick, encoded row == cand_row -> cnt++; when cnt==DEBOUNCE: key_code=
//             col_sel*N_ROWS+cand_row, key_valid=1 -> HOLD. Mismatch/none -> SCAN, column advances.
//   HOLD    : column frozen. Release counter counts consecutive "none" ticks, cleared by any
//             pressed tick. Leave to SCAN (column advances) only when ack done AND release
//             count reached DEBOUNCE.
//  key_valid: set on acceptance, cleared the cycle after key_valid&key_ack; key_code stable while
//   valid. Release before ack keeps valid high; ack with key_valid=0 is ignored.
//  en deasserted in any state -> IDLE next cycle, key_valid cleared, column to 0, counters cleared.
//  CLR mid-operation: all outputs to reset values immediately (asynchronous).
//  Only one key is tracked; other keys pressed during CONFIRM/HOLD are ignored.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in HOLD after ack, while the key stays pressed, key_valid reasserts
//   with the same key_code every RPT_DLY ticks (repeat counter cleared by ack and on release).
//  Not defined: exactly one key_valid per press; RPT_DLY unused, no repeat logic generated.
// STRUCTURE
//  Package keypad_pkg: FSM state enum (IDLE,SCAN,CONFIRM,HOLD), width localparams
//   COL_W=$clog2(N_COLS), CODE_W=$clog2(N_COLS*N_ROWS), ROW_NONE encoding.
//  Sub-module scan_tick_gen: SCAN_DIV divider with sync clear, outputs 1-cycle tick.
//  Top holds synchronizer, row encoder, column counter, FSM, debounce/repeat counters.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE=3, N_COLS=6, N_ROWS=4, RPT_DLY=8)
//  1 en=1, row_in=0 -> col_sel 0,1..5,0 each held 4 cycles; wrap after 24 cycles; key_valid=0.
//  2 row_in=4'b0010 while col_sel=2, held -> key_valid=1, key_code=9 after 3 ticks;
//    stays until key_ack.
//  3 row_in=0010 for 1 tick at col 2, then 0 -> no key_valid; scan resumes at col_sel=3.
//  4 row_in=4'b0110 at col 5 -> key_code=21 (row 1 wins); after ack+3 idle ticks col_sel=0.
//  5 release before ack -> key_valid held, code 9; ack -> valid drops next cycle, SCAN resumes.
//  6 CLR pulse in HOLD -> col_oh=000001, key_valid=0 same cycle; en=0 in CONFIRM -> IDLE next cycle.
//    With KEYPAD_REPEAT_EN: key held 16 ticks after ack -> two further valid pulses, code 9.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad matrix scanner.
// Holds the matrix geometry, derived widths, the "no row pressed" encoding,
// the controller state type and the row priority encoder.
package keypad_pkg;

  localparam int N_COLS = 6;
  localparam int N_ROWS = 4;

  localparam int COL_W  = $clog2(N_COLS);
  localparam int CODE_W = $clog2(N_COLS * N_ROWS);

  // One extra bit beyond the row index so "none" can never alias a real row.
  localparam int ROW_W = $clog2(N_ROWS) + 1;
  localparam logic [ROW_W-1:0] ROW_NONE = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    CONFIRM = 2'd2,
    HOLD    = 2'd3
  } kp_state_e;

  // Lowest-index active row wins; ROW_NONE when all rows are low.
  function automatic logic [ROW_W-1:0] row_encode(input logic [N_ROWS-1:0] rows);
    logic [ROW_W-1:0] enc;
    enc = ROW_NONE;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) enc = ROW_W'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: column dwell divider.
// Counts 0..SCAN_DIV-1 while run is high and flags the last cycle of each
// dwell as a one-cycle tick. The synchronous clear restarts the dwell so a
// freshly selected column always gets a full SCAN_DIV cycles.
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] cnt;

  // Dwell counter: cleared on request, otherwise wraps at the end of a dwell.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (run)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 6-column key matrix scanner with debounce and a
// valid/ack handoff of one key code at a time.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held
// after acknowledgement). Without it, each press yields exactly one key_valid.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 3,
  parameter int RPT_DLY  = 50
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              en,
  input  logic [N_ROWS-1:0] row_in,
  output logic [COL_W-1:0]  col_sel,
  output logic [N_COLS-1:0] col_oh,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

  // Reject parameter values the timing scheme cannot honour.
  if (SCAN_DIV < 2 || DEBOUNCE < 1 || RPT_DLY < 1) begin : g_bad_param
    $error("keypad_scan_ctrl: SCAN_DIV>=2, DEBOUNCE>=1, RPT_DLY>=1 required");
  end

  kp_state_e         state;
  logic [N_ROWS-1:0] row_s1, row_s2;
  logic [ROW_W-1:0]  row_enc, cand_row;
  logic [CNT_W-1:0]  deb_cnt, rel_cnt;
  logic              ack_seen;
  logic              tick, col_adv, div_clear, div_run;
  logic              handshake, ack_done, rel_done, leave_hold, row_none;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(RPT_DLY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_DLY - 1);
  logic [RPT_W-1:0] rpt_cnt;
`endif

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  assign row_enc   = row_encode(row_s2);
  assign row_none  = (row_enc == ROW_NONE);
  assign handshake = key_valid && key_ack;
  assign ack_done  = ack_seen || handshake;

  // Release is complete either already, or on this tick if it is the last idle one needed.
  assign rel_done   = (rel_cnt == DEB_MAX) ||
                      (tick && row_none && (rel_cnt == DEB_MAX - CNT_W'(1)));
  assign leave_hold = (state == HOLD) && ack_done && rel_done;

  assign col_adv = en && ((state == SCAN    && tick && row_none) ||
                          (state == CONFIRM && tick && (row_enc != cand_row)) ||
                          leave_hold);

  assign div_run   = en && (state != IDLE);
  assign div_clear = !en || (state == IDLE) || col_adv;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .CLK  (CLK),
    .CLR  (CLR),
    .clear(div_clear),
    .run  (div_run),
    .tick (tick)
  );

  // Column counter: parked at 0 when idle, advances with wrap on request.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      col_sel <= '0;
    else if (!en || state == IDLE)
      col_sel <= '0;
    else if (col_adv)
      col_sel <= (col_sel == COL_LAST) ? '0 : col_sel + 1'b1;
  end

  assign col_oh = N_COLS'(1) << col_sel;

  // Scan/debounce FSM and key handoff; the handshake clears key_valid unless
  // the state logic below reasserts it in the same cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      cand_row  <= ROW_NONE;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      ack_seen  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else if (!en) begin
      state     <= IDLE;
      cand_row  <= ROW_NONE;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      ack_seen  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      if (handshake) begin
        key_valid <= 1'b0;
        ack_seen  <= 1'b1;
      end
      case (state)
        IDLE: begin
          state <= SCAN;
        end
        SCAN: begin
          if (tick && !row_none) begin
            cand_row <= row_enc;
            deb_cnt  <= CNT_W'(1);
            if (DEBOUNCE == 1) begin
              key_code  <= CODE_W'(col_sel) * CODE_W'(N_ROWS) + CODE_W'(row_enc);
              key_valid <= 1'b1;
              ack_seen  <= 1'b0;
              rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt   <= '0;
`endif
              state     <= HOLD;
            end else begin
              state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (tick) begin
            if (row_enc == cand_row) begin
              if (deb_cnt == DEB_MAX - CNT_W'(1)) begin
                key_code  <= CODE_W'(col_sel) * CODE_W'(N_ROWS) + CODE_W'(row_enc);
                key_valid <= 1'b1;
                ack_seen  <= 1'b0;
                rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                rpt_cnt   <= '0;
`endif
                state     <= HOLD;
              end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
              end
            end else begin
              deb_cnt <= '0;
              state   <= SCAN;
            end
          end
        end
        HOLD: begin
          if (leave_hold) begin
            ack_seen <= 1'b0;
            rel_cnt  <= '0;
            deb_cnt  <= '0;
            state    <= SCAN;
          end else begin
            if (tick) begin
              if (row_none) begin
                if (rel_cnt != DEB_MAX) rel_cnt <= rel_cnt + CNT_W'(1);
              end else begin
                rel_cnt <= '0;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            if (handshake) begin
              rpt_cnt <= '0;
            end else if (tick) begin
              if (row_none) begin
                rpt_cnt <= '0;
              end else if (ack_seen) begin
                if (rpt_cnt == RPT_LAST) begin
                  rpt_cnt   <= '0;
                  key_valid <= 1'b1;
                  ack_seen  <= 1'b0;
                end else begin
                  rpt_cnt <= rpt_cnt + RPT_W'(1);
                end
              end
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
